// File: rtl/psum_pkg.sv
// psum_pkg: shared FSM state encoding for the partial-sum accumulator
package psum_pkg;
  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} psum_state_t;
endpackage

// File: rtl/psum_sat.sv
// psum_sat: combinational signed clip acc[ACC_WIDTH] -> data[OUT_WIDTH] with sat flag when clipped
module psum_sat #(
  parameter int ACC_WIDTH = 48,
  parameter int OUT_WIDTH = 32
) (
  input  logic signed [ACC_WIDTH-1:0] acc,
  output logic        [OUT_WIDTH-1:0] data,
  output logic                        sat
);
  logic [ACC_WIDTH-OUT_WIDTH:0] top;
  assign top  = acc[ACC_WIDTH-1:OUT_WIDTH-1];
  assign sat  = !((&top) || !(|top));
  assign data = sat ? {acc[ACC_WIDTH-1], {(OUT_WIDTH-1){~acc[ACC_WIDTH-1]}}} : acc[OUT_WIDTH-1:0];
endmodule

// File: rtl/psum_accum.sv
// psum_accum: sums cfg_beats signed beats (in_valid/in_ready/in_data) and emits a saturated total (out_valid/out_ready/out_data/out_sat); clk, sync active-high rst
module psum_accum
  import psum_pkg::*;
#(
  parameter  int IN_WIDTH  = 36,
  parameter  int MAX_BEATS = 256,
  parameter  int ACC_WIDTH = 48,
  parameter  int OUT_WIDTH = 32,
  localparam int CNT_WIDTH = $clog2(MAX_BEATS + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic       [CNT_WIDTH-1:0] cfg_beats,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic signed [IN_WIDTH-1:0] in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic       [OUT_WIDTH-1:0] out_data,
  output logic                       out_sat
);
  if (ACC_WIDTH < IN_WIDTH + $clog2(MAX_BEATS) || OUT_WIDTH > ACC_WIDTH) begin : g_bad_width
    $error("psum_accum: ACC_WIDTH must be >= IN_WIDTH + clog2(MAX_BEATS) and >= OUT_WIDTH");
  end
  psum_state_t state_q, state_d;
  logic signed [ACC_WIDTH-1:0] acc_q, acc_d, ext;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d, target_q, target_d, cfg_t;
  logic [OUT_WIDTH-1:0] out_data_q, out_data_d, sat_data;
  logic out_sat_q, out_sat_d, out_valid_q, out_valid_d, sat_flag, hs;
  assign in_ready  = state_q != HOLD;
  assign hs        = in_valid && in_ready;
  assign ext       = ACC_WIDTH'(in_data);
  assign cfg_t     = cfg_beats == '0 ? CNT_WIDTH'(1)
                   : cfg_beats > CNT_WIDTH'(MAX_BEATS) ? CNT_WIDTH'(MAX_BEATS) : cfg_beats;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;
  psum_sat #(.ACC_WIDTH(ACC_WIDTH), .OUT_WIDTH(OUT_WIDTH)) u_sat (
    .acc (acc_d),
    .data(sat_data),
    .sat (sat_flag)
  );
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    target_d = target_q;
    if (state_q == IDLE && hs) begin
      target_d = cfg_t;
      acc_d    = ext;
      cnt_d    = CNT_WIDTH'(1);
      state_d  = cfg_t == CNT_WIDTH'(1) ? HOLD : ACCUM;
    end else if (state_q == ACCUM && hs) begin
      acc_d   = acc_q + ext;
      cnt_d   = cnt_q + CNT_WIDTH'(1);
      state_d = cnt_d == target_q ? HOLD : ACCUM;
    end else if (state_q == HOLD && out_ready) begin
      state_d = IDLE;
    end
    out_valid_d = state_d == HOLD;
    out_data_d  = (out_valid_d && !out_valid_q) ? sat_data : out_data_q;
    out_sat_d   = (out_valid_d && !out_valid_q) ? sat_flag : out_sat_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      target_q    <= '0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      target_q    <= target_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
      out_valid_q <= out_valid_d;
    end
  end
  cfg_range_a: assert property (@(posedge clk) disable iff (rst)
    (hs && state_q == IDLE) |-> cfg_beats <= CNT_WIDTH'(MAX_BEATS));
endmodule

// File: tb/tb_psum_accum.sv
// tb_psum_accum: directed scoreboard bench for psum_accum
module tb_psum_accum;
  logic clk = 1'b0, rst, in_valid, in_ready, out_valid, out_ready, out_sat;
  logic [8:0] cfg_beats;
  logic signed [35:0] in_data;
  logic [31:0] out_data;
  logic [32:0] sb[$];
  logic [32:0] exp_e;
  int n_chk = 0, n_pass = 0, n_out = 0;
  always #5 clk = ~clk;
  psum_accum dut (
    .clk(clk), .rst(rst), .cfg_beats(cfg_beats), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sat(out_sat)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic cyc;
    @(posedge clk);
    #1;
  endtask
  task automatic beat(input logic [8:0] cfg, input longint d);
    in_valid  = 1'b1;
    cfg_beats = cfg;
    in_data   = 36'(d);
    cyc;
    in_valid  = 1'b0;
  endtask
  task automatic push(input longint v, input logic s);
    sb.push_back({s, 32'(v)});
  endtask
  task automatic wait_out(input string tag);
    int s;
    s = n_out;
    for (int i = 0; i < 20 && n_out == s; i++) cyc;
    check(tag, 64'(n_out - s), 64'd1);
  endtask
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      n_out++;
      n_chk++;
      assert (sb.size() != 0) n_pass++;
      else $error("FAIL sb_pop: got output %0h expected none", out_data);
      if (sb.size() != 0) begin
        exp_e = sb.pop_front();
        check("out_data", 64'(out_data), 64'(exp_e[31:0]));
        check("out_sat", 64'(out_sat), 64'(exp_e[32]));
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    longint sum;
    int d;
    int n0;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; cfg_beats = '0; out_ready = 1'b0;
    repeat (2) cyc;
    rst = 1'b0;
    cyc;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_out_sat", 64'(out_sat), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    beat(4, 10); beat(4, -3); beat(4, 7);
    check("basic_early_valid", 64'(out_valid), 64'd0);
    push(114, 1'b0);
    beat(4, 100);
    check("basic_latency", 64'(out_valid), 64'd1);
    check("basic_in_ready", 64'(in_ready), 64'd0);
    repeat (2) cyc;
    check("basic_hold_ready", 64'(in_ready), 64'd0);
    check("basic_hold_data", 64'(out_data), 64'd114);
    out_ready = 1'b1;
    wait_out("basic_hs");
    check("basic_drop", 64'(out_valid), 64'd0);
    check("basic_ready_back", 64'(in_ready), 64'd1);
    push(5, 1'b0);
    beat(1, 5);
    check("one_latency", 64'(out_valid), 64'd1);
    wait_out("one_hs");
    push(-9, 1'b0);
    beat(0, -9);
    check("zero_latency", 64'(out_valid), 64'd1);
    wait_out("zero_hs");
    push(32'h7FFFFFFF, 1'b1);
    beat(2, 64'h7FFFFFFF); beat(2, 64'h7FFFFFFF);
    wait_out("sat_pos_hs");
    push(32'h80000000, 1'b1);
    beat(2, -64'sh80000000); beat(2, -64'sh80000000);
    wait_out("sat_neg_hs");
    push(32'h7FFFFFFF, 1'b0);
    beat(1, 64'h7FFFFFFF);
    wait_out("edge_pos_hs");
    push(32'h80000000, 1'b0);
    beat(1, -64'sh80000000);
    wait_out("edge_neg_hs");
    push(32'h7FFFFFFF, 1'b1);
    beat(1, 64'h80000000);
    wait_out("over_pos_hs");
    sum = 0;
    for (int i = 0; i < 7; i++) begin
      d = int'($urandom_range(2000)) - 1000;
      sum += d;
      beat(8, d);
    end
    d = int'($urandom_range(2000)) - 1000;
    sum += d;
    push(sum, 1'b0);
    beat(8, d);
    wait_out("rand_hs");
    out_ready = 1'b0;
    beat(3, 1);
    cyc;
    beat(3, 2);
    repeat (2) cyc;
    push(6, 1'b0);
    beat(3, 3);
    in_valid = 1'b1; in_data = 36'd999; cfg_beats = 9'd1;
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 64'(out_valid), 64'd1);
      check("bp_data", 64'(out_data), 64'd6);
      check("bp_in_ready", 64'(in_ready), 64'd0);
      cyc;
    end
    in_valid = 1'b0;
    n0 = n_out;
    out_ready = 1'b1;
    wait_out("bp_hs");
    repeat (3) cyc;
    check("bp_one_hs", 64'(n_out - n0), 64'd1);
    beat(4, 50); beat(4, 60);
    rst = 1'b1;
    cyc;
    rst = 1'b0;
    cyc;
    check("midrst_valid", 64'(out_valid), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    push(2, 1'b0);
    beat(2, 1); beat(2, 1);
    wait_out("midrst_hs");
    repeat (3) cyc;
    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
